circle_motion: RTL and testbench
================================

# circle_motion

Per-frame position generator for a circular sprite. On each frame-start pulse it advances a centre coordinate (x_out, y_out) by a programmable speed, reflecting off the screen edges so that the whole circle stays on screen. Its outputs drive the x/y centre inputs of the circle sprite renderer. Coordinates change only once per frame, a few cycles after frame start, so no frame is ever drawn with a half-updated position.

## Interface
Parameters:
- RADIUS, 64, circle radius in pixels. Must be less than V_ACTIVE/2.
- H_ACTIVE, 1280, active pixels per line.
- V_ACTIVE, 720, active lines per frame.
- X_INIT, 640, centre x after reset. Must lie in [RADIUS, H_ACTIVE-1-RADIUS].
- Y_INIT, 360, centre y after reset. Must lie in [RADIUS, V_ACTIVE-1-RADIUS].

Ports:
- clk_in  input  1  pixel clock; the only clock in the block.
- rst_in  input  1  synchronous, active-high reset.
- nf_in  input  1  new-frame strobe; one-cycle pulse, issued during vertical blanking.
- pause_in  input  1  when high at nf_in, the position is frozen for that frame.
- speed_in  input  4  step size in pixels per frame, applied to both axes; unsigned, 0 to 15.
- x_out  output  11  circle centre x.
- y_out  output  10  circle centre y.
- bounce_out  output  1  one-cycle pulse on any frame in which a reflection occurred.
- bounce_count_out  output  16  running count of frames with at least one reflection; wraps.

## Operation
- Derived limits: XMIN = RADIUS, XMAX = H_ACTIVE-1-RADIUS, YMIN = RADIUS, YMAX = V_ACTIVE-1-RADIUS.
- Internal direction bits dir_x and dir_y: 1 means increasing, 0 means decreasing.
- FSM states: WAIT, STEP_X, STEP_Y, COMMIT.
  - WAIT: on nf_in=1 with pause_in=0, latch speed_in into s and go to STEP_X. Otherwise stay in WAIT.
  - STEP_X: compute nx and ndx into staging registers, then go to STEP_Y.
  - STEP_Y: compute ny and ndy into staging registers, then go to COMMIT.
  - COMMIT: load x_out, y_out, dir_x and dir_y from staging. Pulse bounce_out if ndx≠dir_x or ndy≠dir_y. Return to WAIT.
- X step rule, computed in 12-bit unsigned arithmetic with no truncation before compare:
  - dir_x=1 and x+s > XMAX: nx = XMAX, ndx = 0.
  - dir_x=0 and x < XMIN+s: nx = XMIN, ndx = 1.
  - Otherwise: nx = x ± s, and ndx = dir_x.
- Y step rule: identical to the X rule using y, YMIN, YMAX and dir_y, in 11-bit arithmetic.
- Landing exactly on a limit (x+s == XMAX) does not reflect. The next frame's step reflects.
- Corner hit (both axes reflect in the same frame): bounce_out is a single pulse and bounce_count_out increments by 1.
- bounce_count_out increments on the bounce_out cycle and wraps from 0xFFFF to 0x0000.
- s=0: the position is unchanged and no reflection occurs, even when sitting on a limit.
- nf_in arriving in any state other than WAIT is ignored; no queuing.
- pause_in and speed_in are sampled only in WAIT on the nf_in cycle.

## Timing
- Reset values:
  - x_out = X_INIT, y_out = Y_INIT.
  - dir_x = dir_y = 1.
  - bounce_out = 0, bounce_count_out = 0.
  - FSM in WAIT; staging registers cleared.
- Reset mid-update (in STEP_X, STEP_Y or COMMIT) abandons the update. All outputs take their reset values on the next edge.
- Latency: if nf_in is sampled high at edge T, then x_out and y_out take their new values at edge T+3, and bounce_out is high for the single cycle after edge T+3.
- x_out and y_out are stable at all other times. They change at most once per nf_in.
- Minimum nf_in spacing for every pulse to be honoured: 4 cycles.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Reset, then nf_in with speed_in=4 and pause_in=0 → at T+3: x_out=644, y_out=364, bounce_out=0, bounce_count_out=0.
- Right-edge reflection: drive to x_out=1212, dir_x=1, speed 4, then nf_in → x_out=1215, dir_x=0, bounce_out pulses, count=1. Next nf_in → x_out=1211.
- Exact landing: x_out=1211, dir_x=1, speed 4 → x_out=1215 with no bounce. Next frame → x_out=1215, dir_x flips, bounce.
- Corner reflection: x_out=66, y_out=66, both directions decreasing, speed 5 → x_out=64, y_out=64, single bounce_out pulse, count +1.
- pause_in=1 on nf_in, and separately speed_in=0 → outputs unchanged, bounce_out stays 0. A second nf_in pulse 2 cycles after an accepted one → ignored; exactly one update occurs.
- rst_in asserted on cycle T+2 of an update → x_out=640 and y_out=360 next cycle, count=0, no bounce_out pulse; the following nf_in updates normally.

Source files
------------

// File: rtl/circle_motion.sv
// Per-frame centre-position generator for a bouncing circle sprite; updates x/y three
// cycles after each accepted frame-start strobe and reflects off the screen limits.
module circle_motion #(
  parameter int RADIUS   = 64,
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int X_INIT   = 640,
  parameter int Y_INIT   = 360
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        nf_in,
  input  logic        pause_in,
  input  logic [3:0]  speed_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        bounce_out,
  output logic [15:0] bounce_count_out
);

  localparam logic [11:0] XMIN = 12'(RADIUS);
  localparam logic [11:0] XMAX = 12'(H_ACTIVE - 1 - RADIUS);
  localparam logic [10:0] YMIN = 11'(RADIUS);
  localparam logic [10:0] YMAX = 11'(V_ACTIVE - 1 - RADIUS);

  typedef enum logic [1:0] {WAIT, STEP_X, STEP_Y, COMMIT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [3:0]  r_s;
  logic [10:0] r_nx;
  logic        r_ndx;
  logic [9:0]  r_ny;
  logic        r_ndy;
  logic        r_dir_x;
  logic        r_dir_y;

  logic [11:0] w_x_up;
  logic [11:0] w_x_lo;
  logic [10:0] w_x_dn;
  logic [10:0] w_y_up;
  logic [10:0] w_y_lo;
  logic [9:0]  w_y_dn;
  logic [10:0] w_nx;
  logic        w_ndx;
  logic [9:0]  w_ny;
  logic        w_ndy;

  // Widened sums so an overshoot past the limit is seen before any truncation.
  assign w_x_up = {1'b0, x_out} + {8'd0, r_s};
  assign w_x_lo = XMIN + {8'd0, r_s};
  assign w_x_dn = x_out - {7'd0, r_s};
  assign w_y_up = {1'b0, y_out} + {7'd0, r_s};
  assign w_y_lo = YMIN + {7'd0, r_s};
  assign w_y_dn = y_out - {6'd0, r_s};

  always_comb begin
    w_nx  = w_x_dn;
    w_ndx = r_dir_x;
    if (r_dir_x) begin
      if (w_x_up > XMAX) begin
        w_nx  = XMAX[10:0];
        w_ndx = 1'b0;
      end else begin
        w_nx  = w_x_up[10:0];
      end
    end else if ({1'b0, x_out} < w_x_lo) begin
      w_nx  = XMIN[10:0];
      w_ndx = 1'b1;
    end
  end

  always_comb begin
    w_ny  = w_y_dn;
    w_ndy = r_dir_y;
    if (r_dir_y) begin
      if (w_y_up > YMAX) begin
        w_ny  = YMAX[9:0];
        w_ndy = 1'b0;
      end else begin
        w_ny  = w_y_up[9:0];
      end
    end else if ({1'b0, y_out} < w_y_lo) begin
      w_ny  = YMIN[9:0];
      w_ndy = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= WAIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT:    if (nf_in && !pause_in) w_state_nxt = STEP_X;
      STEP_X:  w_state_nxt = STEP_Y;
      STEP_Y:  w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = WAIT;
      default: w_state_nxt = WAIT;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_out            <= 11'(X_INIT);
      y_out            <= 10'(Y_INIT);
      r_dir_x          <= 1'b1;
      r_dir_y          <= 1'b1;
      bounce_out       <= 1'b0;
      bounce_count_out <= 16'd0;
      r_s              <= 4'd0;
      r_nx             <= 11'd0;
      r_ndx            <= 1'b0;
      r_ny             <= 10'd0;
      r_ndy            <= 1'b0;
    end else begin
      bounce_out <= 1'b0;
      case (r_state)
        WAIT: begin
          if (nf_in && !pause_in) r_s <= speed_in;
        end
        STEP_X: begin
          r_nx  <= w_nx;
          r_ndx <= w_ndx;
        end
        STEP_Y: begin
          r_ny  <= w_ny;
          r_ndy <= w_ndy;
        end
        COMMIT: begin
          x_out   <= r_nx;
          y_out   <= r_ny;
          r_dir_x <= r_ndx;
          r_dir_y <= r_ndy;
          // A corner hit flips both directions but still counts as one bounce.
          if ((r_ndx != r_dir_x) || (r_ndy != r_dir_y)) begin
            bounce_out       <= 1'b1;
            bounce_count_out <= bounce_count_out + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_circle_motion.sv
// Directed bench for circle_motion: vector table of frames plus hand-written
// sequences for back-to-back strobes and reset in the middle of an update.
module tb_circle_motion;

  logic        clk = 1'b0;
  logic        rst;
  logic        nf_a;
  logic        nf_b;
  logic        pause;
  logic [3:0]  speed;
  logic [10:0] xa, xb;
  logic [9:0]  ya, yb;
  logic        ba, bb;
  logic [15:0] ca, cb;

  int checks = 0;
  int errors = 0;
  int px[2];
  int py[2];

  typedef struct {
    int b;    // 0: default instance, 1: instance started near the right edge
    int p;
    int s;
    int rep;
    int x;
    int y;
    int bn;
    int c;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  circle_motion u_dut_a (
    .clk_in           (clk),
    .rst_in           (rst),
    .nf_in            (nf_a),
    .pause_in         (pause),
    .speed_in         (speed),
    .x_out            (xa),
    .y_out            (ya),
    .bounce_out       (ba),
    .bounce_count_out (ca)
  );

  circle_motion #(
    .X_INIT (1211),
    .Y_INIT (91)
  ) u_dut_b (
    .clk_in           (clk),
    .rst_in           (rst),
    .nf_in            (nf_b),
    .pause_in         (pause),
    .speed_in         (speed),
    .x_out            (xb),
    .y_out            (yb),
    .bounce_out       (bb),
    .bounce_count_out (cb)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int cur_x(input int b);
    return (b != 0) ? int'(xb) : int'(xa);
  endfunction
  function automatic int cur_y(input int b);
    return (b != 0) ? int'(yb) : int'(ya);
  endfunction
  function automatic int cur_bn(input int b);
    return (b != 0) ? int'(bb) : int'(ba);
  endfunction
  function automatic int cur_c(input int b);
    return (b != 0) ? int'(cb) : int'(ca);
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    for (int r = 0; r < v.rep; r++) begin
      pause = v.p[0];
      speed = v.s[3:0];
      if (v.b != 0) nf_b = 1'b1;
      else          nf_a = 1'b1;
      step();
      nf_a  = 1'b0;
      nf_b  = 1'b0;
      pause = 1'b0;
      step();
      step();
      if (r == 0) begin
        chk($sformatf("v%0d_hold_x", idx), cur_x(v.b), px[v.b]);
        chk($sformatf("v%0d_hold_y", idx), cur_y(v.b), py[v.b]);
      end
      step();
      if (r == v.rep - 1) begin
        chk($sformatf("v%0d_x", idx),      cur_x(v.b),  v.x);
        chk($sformatf("v%0d_y", idx),      cur_y(v.b),  v.y);
        chk($sformatf("v%0d_bounce", idx), cur_bn(v.b), v.bn);
        chk($sformatf("v%0d_count", idx),  cur_c(v.b),  v.c);
      end
      step();
      chk($sformatf("v%0d_bounce_end", idx), cur_bn(v.b), 0);
    end
    px[v.b] = v.x;
    py[v.b] = v.y;
  endtask

  initial begin
    vec_t tv;
    rst   = 1'b1;
    nf_a  = 1'b0;
    nf_b  = 1'b0;
    pause = 1'b0;
    speed = 4'd0;
    px[0] = 640;  py[0] = 360;
    px[1] = 1211; py[1] = 91;

    //           b  p  s  rep  x     y    bn c
    vq.push_back('{0, 0, 4,  1, 644, 364, 0, 0});
    vq.push_back('{0, 0, 15, 19, 929, 649, 0, 0});
    vq.push_back('{0, 0, 15, 1, 944, 655, 1, 1});
    vq.push_back('{0, 0, 15, 17, 1199, 400, 0, 1});
    vq.push_back('{0, 0, 13, 1, 1212, 387, 0, 1});
    vq.push_back('{0, 0, 4,  1, 1215, 383, 1, 2});
    vq.push_back('{0, 0, 4,  1, 1211, 379, 0, 2});
    vq.push_back('{0, 1, 4,  1, 1211, 379, 0, 2});
    vq.push_back('{0, 0, 0,  1, 1211, 379, 0, 2});
    vq.push_back('{1, 0, 4,  1, 1215, 95,  0, 0});
    vq.push_back('{1, 0, 15, 1, 1215, 110, 1, 1});
    vq.push_back('{1, 0, 15, 36, 675, 650, 0, 1});
    vq.push_back('{1, 0, 5,  1, 670, 655, 0, 1});
    vq.push_back('{1, 0, 15, 1, 655, 655, 1, 2});
    vq.push_back('{1, 0, 15, 39, 70, 70,  0, 2});
    vq.push_back('{1, 0, 4,  1, 66,  66,  0, 2});
    vq.push_back('{1, 0, 5,  1, 64,  64,  1, 3});
    vq.push_back('{1, 0, 0,  1, 64,  64,  0, 3});
    vq.push_back('{1, 0, 5,  1, 69,  69,  0, 3});

    step();
    step();
    step();
    rst = 1'b0;
    chk("rst_x",      int'(xa), 640);
    chk("rst_y",      int'(ya), 360);
    chk("rst_bounce", int'(ba), 0);
    chk("rst_count",  int'(ca), 0);
    chk("rst_b_x",    int'(xb), 1211);
    chk("rst_b_y",    int'(yb), 91);

    foreach (vq[i]) run_vec(i, vq[i]);

    // Second strobe two cycles after an accepted one must be dropped.
    speed = 4'd4;
    nf_a  = 1'b1;
    step();
    nf_a = 1'b0;
    step();
    nf_a  = 1'b1;
    speed = 4'd15;
    step();
    nf_a  = 1'b0;
    speed = 4'd0;
    chk("dbl_hold_x", int'(xa), 1211);
    step();
    chk("dbl_x", int'(xa), 1207);
    chk("dbl_y", int'(ya), 375);
    step();
    chk("dbl_bounce", int'(ba), 0);
    for (int k = 0; k < 5; k++) step();
    chk("dbl_late_x",     int'(xa), 1207);
    chk("dbl_late_y",     int'(ya), 375);
    chk("dbl_late_count", int'(ca), 2);

    // Reset landing on the STEP_Y -> COMMIT edge abandons the update.
    speed = 4'd4;
    nf_a  = 1'b1;
    step();
    nf_a = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_x",      int'(xa), 640);
    chk("mid_rst_y",      int'(ya), 360);
    chk("mid_rst_bounce", int'(ba), 0);
    chk("mid_rst_count",  int'(ca), 0);
    step();
    chk("mid_rst_b1", int'(ba), 0);
    chk("mid_rst_x1", int'(xa), 640);
    step();
    chk("mid_rst_b2", int'(ba), 0);
    chk("mid_rst_y2", int'(ya), 360);
    px[0] = 640;
    py[0] = 360;
    tv = '{0, 0, 4, 1, 644, 364, 0, 0};
    run_vec(99, tv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
